bcd_seg_display_driver: RTL and testbench

//  Downstream consumer of the 12-bit binary-to-BCD converter. Periodically requests a

---
 rtl/bcd_seg_display_driver.sv | 175 +++++++++++++++++
 tb/tb_bcd_seg_display_driver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seg_display_driver
// Brief    : Periodically requests a binary-to-BCD conversion, captures the
//            4-digit packed BCD result on the converter's ready pulse, and
//            drives a 4-digit time-multiplexed common-anode 7-seg display.
// Options  : BCD_DISP_BLANK_LZ_EN - when defined, leading zeros are blanked
//            (digit 0 is never blanked; nibbles > 9 count as nonzero).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_seg_display_driver #(
  parameter int REFRESH_DIV = 100000,   // dwell per digit, >= 2
  parameter int SAMPLE_DIV  = 10000000, // idle cycles between requests, >= 1
  parameter int TIMEOUT     = 255       // max wait cycles for bcd_rdy
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_rdy,
  output logic        conv_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        timeout_err
);

  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int SMP_W = $clog2(SAMPLE_DIV + 1);
  localparam int WT_W  = $clog2(TIMEOUT + 1);

  localparam logic [REF_W-1:0] C_REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [SMP_W-1:0] C_SMP_LAST  = SMP_W'(SAMPLE_DIV - 1);
  localparam logic [WT_W-1:0]  C_WAIT_LAST = WT_W'(TIMEOUT - 1);
  localparam logic [6:0]       C_SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       disp_q, disp_d;
  logic              terr_q, terr_d;
  logic              conv_en_q, conv_en_d;
  logic [WT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        nib;
  logic              blank;

  // Active-low gfedcba pattern for one BCD nibble; invalid codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Request FSM: pulse conv_en, wait for ready (bounded), then idle until next sample.
  always_comb begin
    state_d    = state_q;
    disp_d     = disp_q;
    terr_d     = terr_q;
    conv_en_d  = 1'b0;
    wait_cnt_d = wait_cnt_q;
    smp_cnt_d  = smp_cnt_q;
    case (state_q)
      ST_REQ: begin
        conv_en_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A ready pulse on the terminal count still counts as an answer.
        if (bcd_rdy) begin
          disp_d    = bcd_in;
          terr_d    = 1'b0;
          smp_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (wait_cnt_q == C_WAIT_LAST) begin
          terr_d    = 1'b1;
          smp_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (smp_cnt_q == C_SMP_LAST) begin
          smp_cnt_d = '0;
          state_d   = ST_REQ;
        end else begin
          smp_cnt_d = smp_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Digit scan and registered anode/segment/dp generation.
  always_comb begin
    ref_cnt_d = ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (ref_cnt_q == C_REF_LAST) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
    nib = disp_q[{idx_q, 2'b00} +: 4];
`ifdef BCD_DISP_BLANK_LZ_EN
    case (idx_q)
      2'd3:    blank = (disp_q[15:12] == 4'h0);
      2'd2:    blank = (disp_q[15:8]  == 8'h00);
      2'd1:    blank = (disp_q[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? C_SEG_BLANK : seg_decode(nib);
    dp_d  = ~((idx_q == 2'd0) & terr_q);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      disp_q     <= 16'h0000;
      terr_q     <= 1'b0;
      conv_en_q  <= 1'b0;
      wait_cnt_q <= '0;
      smp_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      idx_q      <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= C_SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      disp_q     <= disp_d;
      terr_q     <= terr_d;
      conv_en_q  <= conv_en_d;
      wait_cnt_q <= wait_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign conv_en     = conv_en_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seg_display_driver
// Brief    : Scoreboard bench for bcd_seg_display_driver with a directed
//            converter model (answers 63 cycles after conv_en, or stays silent).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_seg_display_driver;

  localparam int REFRESH_DIV = 4;
  localparam int SAMPLE_DIV  = 200;
  localparam int TIMEOUT     = 100;
  localparam int K_IMM       = 0;
  localparam int K_DIG       = 1;

`ifdef BCD_DISP_BLANK_LZ_EN
  localparam logic [6:0] Z_LEAD = 7'b1111111;
`else
  localparam logic [6:0] Z_LEAD = 7'b1000000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        bcd_rdy = 1'b0;
  logic        conv_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        timeout_err;

  always #5 clk = ~clk;

  bcd_seg_display_driver #(
    .REFRESH_DIV(REFRESH_DIV),
    .SAMPLE_DIV (SAMPLE_DIV),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .bcd_rdy    (bcd_rdy),
    .conv_en    (conv_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .timeout_err(timeout_err)
  );

  typedef struct {
    int         kind;
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       conv;
    logic       terr;
    bit         c_disp;
    bit         c_an;
    bit         c_conv;
    bit         c_terr;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n;

  // Clock edges since reset release, used to predict the anode scan phase.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  task automatic cmp(input string name, input string fld,
                     input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%b required=%b", name, fld, act, req);
    end
  endtask

  // Monitor: immediate records compare this cycle; digit records wait for their anode.
  initial begin : monitor
    exp_t e;
    int   wait_cyc;
    wait_cyc = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        if (e.kind == K_IMM) begin
          if (e.c_an || e.c_disp) cmp(e.name, "an", {3'b000, an}, {3'b000, e.an});
          if (e.c_disp) begin
            cmp(e.name, "seg", seg, e.seg);
            cmp(e.name, "dp", {6'b0, dp}, {6'b0, e.dp});
          end
          if (e.c_conv) cmp(e.name, "conv_en", {6'b0, conv_en}, {6'b0, e.conv});
          if (e.c_terr) cmp(e.name, "timeout_err", {6'b0, timeout_err}, {6'b0, e.terr});
          e = sb_q.pop_front();
        end else if (an === e.an) begin
          cmp(e.name, "seg", seg, e.seg);
          cmp(e.name, "dp", {6'b0, dp}, {6'b0, e.dp});
          cmp(e.name, "timeout_err", {6'b0, timeout_err}, {6'b0, e.terr});
          e = sb_q.pop_front();
          wait_cyc = 0;
        end else begin
          wait_cyc++;
          if (wait_cyc > 20) begin
            cmp(e.name, "an_never_seen", {3'b000, an}, {3'b000, e.an});
            e = sb_q.pop_front();
            wait_cyc = 0;
          end
        end
      end
    end
  end

  task automatic push_imm(input string name, input bit c_disp, input logic [3:0] a,
                          input logic [6:0] s, input logic d, input bit c_conv,
                          input logic cv, input bit c_terr, input logic te);
    exp_t e;
    e.kind = K_IMM; e.name = name; e.an = a; e.seg = s; e.dp = d; e.conv = cv;
    e.terr = te; e.c_disp = c_disp; e.c_an = 1'b0; e.c_conv = c_conv; e.c_terr = c_terr;
    sb_q.push_back(e);
  endtask

  task automatic push_an(input string name, input logic [3:0] a);
    exp_t e;
    e.kind = K_IMM; e.name = name; e.an = a; e.seg = 7'h00; e.dp = 1'b1; e.conv = 1'b0;
    e.terr = 1'b0; e.c_disp = 1'b0; e.c_an = 1'b1; e.c_conv = 1'b0; e.c_terr = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic push_dig(input string name, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic te);
    exp_t e;
    e.kind = K_DIG; e.name = name; e.an = a; e.seg = s; e.dp = d; e.conv = 1'b0;
    e.terr = te; e.c_disp = 1'b0; e.c_an = 1'b0; e.c_conv = 1'b0; e.c_terr = 1'b0;
    sb_q.push_back(e);
  endtask

  // Four digit expectations, ones digit first; dp lights on digit 0 only with an error.
  task automatic push_frame(input string name, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0, input logic te);
    push_dig({name, "_d0"}, 4'b1110, s0, ~te, te);
    push_dig({name, "_d1"}, 4'b1101, s1, 1'b1, te);
    push_dig({name, "_d2"}, 4'b1011, s2, 1'b1, te);
    push_dig({name, "_d3"}, 4'b0111, s3, 1'b1, te);
  endtask

  function automatic logic [3:0] an_at(input int n);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (((n - 1) / 4) % 4));
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_conv(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (conv_en !== 1'b1 && n < 400);
    if (conv_en !== 1'b1) push_imm(name, 1'b0, 4'b0, 7'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Converter model: ready pulse sampled n edges after the current one.
  task automatic answer(input int n, input logic [15:0] v);
    repeat (n - 1) step();
    bcd_in  = v;
    bcd_rdy = 1'b1;
    step();
    bcd_rdy = 1'b0;
    bcd_in  = 16'hEEEE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
  endtask

  // Directed scenario sequence.
  initial begin : stim
    repeat (3) step();
    push_imm("rst_vals", 1'b1, 4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    step();
    push_imm("conv_first", 1'b1, 4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    push_imm("conv_pulse_end", 1'b0, 4'b0, 7'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    answer(62, 16'h0123);
    step();
    push_frame("t1_0123", Z_LEAD, 7'b1111001, 7'b0100100, 7'b0110000, 1'b0);
    drain();

    for (int i = 0; i < 32; i++) begin
      step();
      push_an("t2_scan", an_at(edge_n));
    end
    drain();

    wait_conv("t3_conv");
    repeat (TIMEOUT - 1) step();
    push_imm("t3_err_early", 1'b0, 4'b0, 7'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    push_imm("t3_err_set", 1'b0, 4'b0, 7'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    push_frame("t3_hold", Z_LEAD, 7'b1111001, 7'b0100100, 7'b0110000, 1'b1);
    drain();
    wait_conv("t3b_conv");
    answer(63, 16'h4095);
    step();
    push_frame("t3_4095", 7'b0011001, 7'b1000000, 7'b0010000, 7'b0010010, 1'b0);
    drain();

    wait_conv("t4_conv");
    answer(TIMEOUT, 16'h0007);
    step();
    push_frame("t4_edge", Z_LEAD, Z_LEAD, Z_LEAD, 7'b1111000, 1'b0);
    drain();

    bcd_in  = 16'h9999;
    bcd_rdy = 1'b1;
    step();
    bcd_rdy = 1'b0;
    bcd_in  = 16'hEEEE;
    push_imm("t5_spur", 1'b0, 4'b0, 7'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    push_frame("t5_ignore", Z_LEAD, Z_LEAD, Z_LEAD, 7'b1111000, 1'b0);
    drain();
    wait_conv("t5_conv");
    answer(63, 16'h00AF);
    step();
    push_frame("t5_dash", Z_LEAD, Z_LEAD, 7'b0111111, 7'b0111111, 1'b0);
    drain();

    wait_conv("t6_conv_a");
    repeat (TIMEOUT + 1) step();
    push_imm("t6_pre_err", 1'b0, 4'b0, 7'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    wait_conv("t6_conv_b");
    repeat (20) step();
    rst     = 1'b1;
    bcd_in  = 16'h5555;
    bcd_rdy = 1'b1;
    push_imm("t6_rst_async", 1'b1, 4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    push_imm("t6_rst_hold", 1'b1, 4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    step();
    bcd_rdy = 1'b0;
    bcd_in  = 16'hEEEE;
    push_imm("t6_conv_first", 1'b1, 4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    push_imm("t6_conv_end", 1'b0, 4'b0, 7'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) step();
    push_frame("t6_zero", Z_LEAD, Z_LEAD, Z_LEAD, 7'b1000000, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
